// File: rtl/hazard_ctrl_pipe.sv
// Pipeline control registers (ID/EX, EX/MEM, MEM/WB) with load-use stall,
// taken-branch flush and EX-stage operand forwarding selects.
module hazard_ctrl_pipe #(
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_ALUSrc,
  input  logic            id_MemtoReg,
  input  logic            id_RegWrite,
  input  logic            id_MemRead,
  input  logic            id_MemWrite,
  input  logic            id_Branch,
  input  logic [1:0]      id_ALUOp,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            mem_zero,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic            ex_ALUSrc,
  output logic [1:0]      ex_ALUOp,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [RA_W-1:0] ex_rd,
  output logic            mem_MemRead,
  output logic            mem_MemWrite,
  output logic            mem_Branch,
  output logic            mem_RegWrite,
  output logic            mem_MemtoReg,
  output logic [RA_W-1:0] mem_rd,
  output logic            wb_RegWrite,
  output logic            wb_MemtoReg,
  output logic [RA_W-1:0] wb_rd,
  output logic [1:0]      forward_a,
  output logic [1:0]      forward_b,
  output logic            branch_taken
);

  typedef struct packed {
    logic            alusrc;
    logic [1:0]      aluop;
    logic            memread;
    logic            memwrite;
    logic            branch;
    logic            regwrite;
    logic            memtoreg;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic            memread;
    logic            memwrite;
    logic            branch;
    logic            regwrite;
    logic            memtoreg;
    logic [RA_W-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic            regwrite;
    logic            memtoreg;
    logic [RA_W-1:0] rd;
  } memwb_t;

  idex_t  idex_d,  idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;

  logic load_use;
  logic flush;

  // A load in EX whose destination feeds the instruction in ID; x0 never matches.
  assign load_use = idex_q.memread && (idex_q.rd != '0) &&
                    ((idex_q.rd == id_rs1) || (idex_q.rd == id_rs2));
  assign flush    = exmem_q.branch & mem_zero;

  // Flush wins over stall: the stalled instruction is on the wrong path anyway.
  assign pc_write     = ~load_use | flush;
  assign ifid_write   = ~load_use | flush;
  assign ifid_flush   = flush;
  assign branch_taken = flush;

  always_comb begin
    // NOTE: every signal gets a default before any conditional update so no latch is inferred.
    idex_d     = '0;
    idex_d.rs1 = id_rs1;
    idex_d.rs2 = id_rs2;
    idex_d.rd  = id_rd;
    if (!(load_use || flush)) begin
      idex_d.alusrc   = id_ALUSrc;
      idex_d.aluop    = id_ALUOp;
      idex_d.memread  = id_MemRead;
      idex_d.memwrite = id_MemWrite;
      idex_d.branch   = id_Branch;
      idex_d.regwrite = id_RegWrite;
      idex_d.memtoreg = id_MemtoReg;
    end

    exmem_d    = '0;
    exmem_d.rd = idex_q.rd;
    if (!flush) begin
      exmem_d.memread  = idex_q.memread;
      exmem_d.memwrite = idex_q.memwrite;
      exmem_d.branch   = idex_q.branch;
      exmem_d.regwrite = idex_q.regwrite;
      exmem_d.memtoreg = idex_q.memtoreg;
    end

    memwb_d.regwrite = exmem_q.regwrite;
    memwb_d.memtoreg = exmem_q.memtoreg;
    memwb_d.rd       = exmem_q.rd;
  end

  // NOTE: these are control flops, not storage arrays, so every bit is reset; a reset
  // mid-stall or mid-flush must leave no stale control behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      // NOTE: non-blocking so all three stages sample the pre-edge values together.
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // EX/MEM result is newer than MEM/WB, so it takes priority.
  always_comb begin
    forward_a = 2'b00;
    if (exmem_q.regwrite && (exmem_q.rd != '0) && (exmem_q.rd == idex_q.rs1))
      forward_a = 2'b10;
    else if (memwb_q.regwrite && (memwb_q.rd != '0) && (memwb_q.rd == idex_q.rs1))
      forward_a = 2'b01;

    forward_b = 2'b00;
    if (exmem_q.regwrite && (exmem_q.rd != '0) && (exmem_q.rd == idex_q.rs2))
      forward_b = 2'b10;
    else if (memwb_q.regwrite && (memwb_q.rd != '0) && (memwb_q.rd == idex_q.rs2))
      forward_b = 2'b01;
  end

  assign ex_ALUSrc    = idex_q.alusrc;
  assign ex_ALUOp     = idex_q.aluop;
  assign ex_rs1       = idex_q.rs1;
  assign ex_rs2       = idex_q.rs2;
  assign ex_rd        = idex_q.rd;
  assign mem_MemRead  = exmem_q.memread;
  assign mem_MemWrite = exmem_q.memwrite;
  assign mem_Branch   = exmem_q.branch;
  assign mem_RegWrite = exmem_q.regwrite;
  assign mem_MemtoReg = exmem_q.memtoreg;
  assign mem_rd       = exmem_q.rd;
  assign wb_RegWrite  = memwb_q.regwrite;
  assign wb_MemtoReg  = memwb_q.memtoreg;
  assign wb_rd        = memwb_q.rd;

endmodule
